// File: rtl/ifu_pkg.sv
// Instruction fetch unit shared definitions: opcode values, opcode field
// position and the sequencer state encoding.
package ifu_pkg;

  localparam int OPC_W   = 6;
  localparam int OPC_MSB = 59;
  localparam int OPC_LSB = 54;

  localparam logic [OPC_W-1:0] OP_NOP    = 6'd0;
  localparam logic [OPC_W-1:0] OP_ADD    = 6'd1;
  localparam logic [OPC_W-1:0] OP_SUB    = 6'd2;
  localparam logic [OPC_W-1:0] OP_LOAD   = 6'd3;
  localparam logic [OPC_W-1:0] OP_STORE  = 6'd4;
  localparam logic [OPC_W-1:0] OP_BRANCH = 6'd5;
  localparam logic [OPC_W-1:0] OP_JUMP   = 6'd6;
  localparam logic [OPC_W-1:0] OP_HALT   = 6'd63;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    RESOLVE = 2'd2,
    HALT    = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: absolute jump, taken relative branch, or sequential.
// All arithmetic wraps modulo 2^ADDR_W.
module instr_fetch_unit_next_pc_calc #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [15:0]       imm_i,
  input  logic              branch_i,
  input  logic              jump_i,
  input  logic              zero_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

  logic [EXT_W-1:0]  imm_ext;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_pc;

  assign imm_ext = EXT_W'($signed(imm_i));
  assign seq_pc  = pc_i + ADDR_W'(1);
  assign br_pc   = seq_pc + imm_ext[ADDR_W-1:0];

  // Jump outranks branch so an illegal jump+branch decode still has a defined target.
  always_comb begin
    next_pc_o = seq_pc;
    if (jump_i) begin
      next_pc_o = target_i;
    end else if (branch_i && zero_i) begin
      next_pc_o = br_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-pipelined fetch/issue sequencer: fetches one instruction, holds it
// while the control unit decodes it, then resolves the next PC and retires.
// Optional HALT support is enabled by defining IFU_HALT_EN.
//
// state   | meaning
// FETCH   | imem_req high at imem_addr=pc, waiting for imem_ready
// DECODE  | ir loaded, opcode presented to control unit for one cycle
// RESOLVE | instr_valid high, branch/jump sampled, retire unless stall
// HALT    | halt instruction retired, idle until reset (IFU_HALT_EN only)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 60,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [5:0]         op,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  input  logic               stall,
  output logic [ADDR_W-1:0]  pc,
  output logic [31:0]        retired_count,
  output logic               halted
);

  ifu_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               req_q;
  logic               valid_q;
  logic [31:0]        retired_q;
  logic [ADDR_W-1:0]  next_pc_d;
  logic [OPC_W-1:0]   op_w;

  // Opcode is a continuous slice of ir so it stays stable through DECODE and RESOLVE.
  assign op_w = ir_q[INSTR_W-1 -: OPC_W];

  instr_fetch_unit_next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i      (pc_q),
    .target_i  (ir_q[ADDR_W-1:0]),
    .imm_i     (ir_q[15:0]),
    .branch_i  (branch),
    .jump_i    (jump),
    .zero_i    (zero),
    .next_pc_o (next_pc_d)
  );

`ifdef IFU_HALT_EN
  logic halted_q;

  // Sequencer FSM with registered request/valid/halt outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && imem_ready) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= DECODE;
          end else begin
            req_q <= 1'b1;
          end
        end
        DECODE: begin
          valid_q <= 1'b1;
          state_q <= RESOLVE;
        end
        RESOLVE: begin
          if (!stall) begin
            retired_q <= retired_q + 32'd1;
            valid_q   <= 1'b0;
            if (op_w == OP_HALT) begin
              // pc keeps the halt instruction's address while halted
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_q;
`else
  // Sequencer FSM with registered request/valid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && imem_ready) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= DECODE;
          end else begin
            req_q <= 1'b1;
          end
        end
        DECODE: begin
          valid_q <= 1'b1;
          state_q <= RESOLVE;
        end
        RESOLVE: begin
          if (!stall) begin
            retired_q <= retired_q + 32'd1;
            valid_q   <= 1'b0;
            pc_q      <= next_pc_d;
            req_q     <= 1'b1;
            state_q   <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted = 1'b0;
`endif

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign op            = op_w;
  assign instr_out     = ir_q;
  assign instr_valid   = valid_q;
  assign pc            = pc_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against an
// arithmetic next-PC / retire-count reference model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [59:0] imem_rdata;
  logic [5:0]  op;
  logic [59:0] instr_out;
  logic        instr_valid;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        stall;
  logic [15:0] pc;
  logic [31:0] retired_count;
  logic        halted;

  int          n_pass;
  int          n_total;
  logic [15:0] exp_pc;
  logic [31:0] exp_ret;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .op            (op),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .branch        (branch),
    .jump          (jump),
    .zero          (zero),
    .stall         (stall),
    .pc            (pc),
    .retired_count (retired_count),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
  endtask

  // Reference next address computed directly from the branching rules.
  function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [59:0] ins,
                                             input bit br, input bit jp, input bit z);
    int t;
    logic [15:0] imm;
    imm = ins[15:0];
    if (jp) return imm;
    if (br && z) begin
      t = int'(cur) + 1 + int'($signed(imm));
      return 16'(t);
    end
    t = int'(cur) + 1;
    return 16'(t);
  endfunction

  function automatic logic [59:0] mk(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 38'h0, imm};
  endfunction

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("fetch_req", {63'd0, imem_req}, 64'd1);
  endtask

  // One full fetch/decode/resolve transaction with optional ready delay and stall.
  task automatic run_instr(input logic [59:0] ins, input int dly, input bit br,
                           input bit jp, input bit z, input int stl);
    logic [5:0] opc;
    opc = ins[59:54];
    wait_req();
    check("fetch_addr", 64'(imem_addr), 64'(exp_pc));
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
    end
    if (dly > 0) begin
      check("req_held", {63'd0, imem_req}, 64'd1);
      check("addr_held", 64'(imem_addr), 64'(exp_pc));
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 60'({$urandom, $urandom});
    check("decode_req", {63'd0, imem_req}, 64'd0);
    check("decode_valid", {63'd0, instr_valid}, 64'd0);
    check("decode_op", 64'(op), 64'(opc));
    branch = br;
    jump   = jp;
    zero   = z;
    stall  = (stl > 0);
    @(posedge clk); #1;
    check("resolve_valid", {63'd0, instr_valid}, 64'd1);
    check("resolve_pc", 64'(pc), 64'(exp_pc));
    check("resolve_ir", 64'(instr_out), 64'(ins));
    for (int i = 0; i < stl; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, instr_valid}, 64'd1);
      check("stall_pc", 64'(pc), 64'(exp_pc));
      check("stall_op", 64'(op), 64'(opc));
      check("stall_retired", 64'(retired_count), 64'(exp_ret));
      if (i == stl - 1) stall = 1'b0;
    end
    @(posedge clk); #1;
    exp_pc  = model_next(exp_pc, ins, br, jp, z);
    exp_ret = exp_ret + 32'd1;
    branch  = 1'b0;
    jump    = 1'b0;
    zero    = 1'b0;
    check("retired", 64'(retired_count), 64'(exp_ret));
    check("post_valid", {63'd0, instr_valid}, 64'd0);
    check("next_req", {63'd0, imem_req}, 64'd1);
    check("next_addr", 64'(imem_addr), 64'(exp_pc));
    check("not_halted", {63'd0, halted}, 64'd0);
  endtask

  initial begin
    logic [59:0] ins;
    logic [5:0]  ropc;
    n_pass     = 0;
    n_total    = 0;
    exp_pc     = 16'h0000;
    exp_ret    = 32'd0;
    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;
    stall      = 1'b0;

    #12;
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_op", 64'(op), 64'd0);
    check("rst_ir", 64'(instr_out), 64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    check("req_low_after_release", {63'd0, imem_req}, 64'd0);
    @(posedge clk); #1;
    check("req_rise", {63'd0, imem_req}, 64'd1);
    check("first_addr", 64'(imem_addr), 64'd0);

    // Three sequential ADDs at 0,1,2 with immediate ready.
    for (int i = 0; i < 3; i++) run_instr(mk(6'd1, 16'h1234), 0, 1'b0, 1'b0, 1'b0, 0);
    check("seq_retired3", 64'(retired_count), 64'd3);
    check("seq_addr3", 64'(imem_addr), 64'd3);

    run_instr(mk(6'd1, 16'h0000), 0, 1'b0, 1'b0, 1'b0, 0);
    run_instr(mk(6'd1, 16'h0000), 0, 1'b0, 1'b0, 1'b0, 0);
    check("at_pc5", 64'(imem_addr), 64'h5);
    run_instr(mk(6'd6, 16'h0040), 0, 1'b0, 1'b1, 1'b0, 0);
    check("jump_target", 64'(imem_addr), 64'h40);

    run_instr(mk(6'd6, 16'h0010), 0, 1'b0, 1'b1, 1'b0, 0);
    run_instr(mk(6'd5, 16'hFFFC), 0, 1'b1, 1'b0, 1'b1, 0);
    check("branch_taken", 64'(imem_addr), 64'h000D);
    run_instr(mk(6'd6, 16'h0010), 1, 1'b0, 1'b1, 1'b0, 0);
    run_instr(mk(6'd5, 16'hFFFC), 0, 1'b1, 1'b0, 1'b0, 0);
    check("branch_not_taken", 64'(imem_addr), 64'h0011);

    // Jump and branch both asserted: jump wins.
    run_instr(mk(6'd5, 16'h0030), 0, 1'b1, 1'b1, 1'b1, 0);
    check("jump_over_branch", 64'(imem_addr), 64'h0030);

    run_instr(mk(6'd2, 16'h0055), 0, 1'b0, 1'b0, 1'b0, 4);
    check("stall_retire_once", 64'(retired_count), 64'(exp_ret));

    run_instr(mk(6'd6, 16'hFFFF), 2, 1'b0, 1'b1, 1'b0, 0);
    check("at_ffff", 64'(imem_addr), 64'hFFFF);
    run_instr(mk(6'd1, 16'h0000), 0, 1'b0, 1'b0, 1'b0, 0);
    check("wrap_to_zero", 64'(imem_addr), 64'h0000);

    // Backward branch below zero wraps.
    run_instr(mk(6'd5, 16'hFFF0), 0, 1'b1, 1'b0, 1'b1, 0);
    check("branch_wrap", 64'(imem_addr), 64'hFFF1);

`ifndef IFU_HALT_EN
    run_instr(mk(6'd63, 16'h0000), 0, 1'b0, 1'b0, 1'b0, 0);
    check("op63_ordinary", 64'(imem_addr), 64'hFFF2);
`endif

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      ins = 60'({$urandom, $urandom});
`ifdef IFU_HALT_EN
      ropc = 6'($urandom_range(0, 62));
`else
      ropc = 6'($urandom_range(0, 63));
`endif
      ins[59:54] = ropc;
      run_instr(ins, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    // Delayed ready, then asynchronous reset while in DECODE.
    wait_req();
    check("pre_reset_addr", 64'(imem_addr), 64'(exp_pc));
    repeat (3) begin
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    imem_rdata = mk(6'd5, 16'h0077);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check("mid_decode_op", 64'(op), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check("async_req", {63'd0, imem_req}, 64'd0);
    check("async_valid", {63'd0, instr_valid}, 64'd0);
    check("async_pc", 64'(pc), 64'd0);
    check("async_op", 64'(op), 64'd0);
    check("async_retired", 64'(retired_count), 64'd0);
    check("async_halted", {63'd0, halted}, 64'd0);
    imem_ready = 1'b1;
    imem_rdata = mk(6'd2, 16'h0099);
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_pc  = 16'h0000;
    exp_ret = 32'd0;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check("stale_ready_ignored", 64'(op), 64'd0);
    check("refetch_req", {63'd0, imem_req}, 64'd1);
    check("refetch_addr", 64'(imem_addr), 64'd0);
    run_instr(mk(6'd3, 16'h0000), 0, 1'b0, 1'b0, 1'b0, 0);
    check("post_reset_addr", 64'(imem_addr), 64'd1);

`ifdef IFU_HALT_EN
    // Halt instruction retires and the unit goes idle.
    wait_req();
    imem_ready = 1'b1;
    imem_rdata = mk(6'd63, 16'h0000);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    check("halt_resolve_valid", {63'd0, instr_valid}, 64'd1);
    @(posedge clk); #1;
    exp_ret = exp_ret + 32'd1;
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_retired", 64'(retired_count), 64'(exp_ret));
    check("halt_valid", {63'd0, instr_valid}, 64'd0);
    imem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("halt_req_low", {63'd0, imem_req}, 64'd0);
      check("halt_pc_frozen", 64'(pc), 64'(exp_pc));
    end
    imem_ready = 1'b0;
    check("halt_sticky", {63'd0, halted}, 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
